// File: rtl/seq_detector_if.sv
// Symbol-stream bundle between a source and the sequence detector.
// Handshake: the source asserts in_valid for exactly the cycles in which
// in_sym carries a symbol; the detector has no backpressure and takes every
// valid symbol on the rising edge where in_valid is high. match, progress and
// hit_cnt are registered detector outputs and may be sampled on any cycle.
interface seq_detector_if #(
   parameter int SYM_W   = 2,
   parameter int SEQ_LEN = 3,
   parameter int CNT_W   = 8
);
   logic                               in_valid;
   logic [SYM_W-1:0]                   in_sym;
   logic                               match;
   logic [$clog2(SEQ_LEN+1)-1:0]       progress;
   logic [CNT_W-1:0]                   hit_cnt;

   modport master (output in_valid, in_sym, input match, progress, hit_cnt);
   modport slave  (input in_valid, in_sym, output match, progress, hit_cnt);
endinterface

// File: rtl/seq_detector.sv
// Run-time programmable symbol-sequence detector with KMP-style fallback,
// optional overlapping matches and a saturating hit counter.
module seq_detector #(
   parameter int SYM_W   = 2,
   parameter int SEQ_LEN = 3,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic [SEQ_LEN*SYM_W-1:0]   cfg_seq,
   input  logic                       cfg_overlap,
   seq_detector_if.slave              sym_if
);
   localparam int PW = $clog2(SEQ_LEN+1);

   logic [PW-1:0]    p_q, p_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   int               border;
   int               q;
   int               p_i;
   logic             ok_b;
   logic             ok_q;

   // Symbol idx of the pattern; symbol 0 sits in the low bits.
   function automatic logic [SYM_W-1:0] sym_at(input logic [SEQ_LEN*SYM_W-1:0] vec,
                                                input int idx);
      return SYM_W'(vec >> (idx*SYM_W));
   endfunction

   // Longest proper border of the whole pattern: where to resume after an
   // overlapping match.
   always_comb begin
      border = 0;
      ok_b   = 1'b0;
      for (int k = 1; k < SEQ_LEN; k++) begin
         ok_b = 1'b1;
         for (int j = 0; j < SEQ_LEN-1; j++) begin
            if (j < k) begin
               if (sym_at(cfg_seq, j) != sym_at(cfg_seq, SEQ_LEN-k+j)) ok_b = 1'b0;
            end
         end
         if (ok_b) border = k;
      end
   end

   // Candidate progress q: extend on a hit, otherwise the longest pattern
   // prefix that is a suffix of (matched prefix, in_sym).
   always_comb begin
      p_i  = int'(p_q);
      q    = 0;
      ok_q = 1'b0;
      if (sym_if.in_sym == sym_at(cfg_seq, p_i)) begin
         q = p_i + 1;
      end else begin
         for (int k = 1; k < SEQ_LEN; k++) begin
            if (k <= p_i) begin
               ok_q = (sym_at(cfg_seq, k-1) == sym_if.in_sym);
               for (int j = 0; j < SEQ_LEN-1; j++) begin
                  if (j < k-1) begin
                     if (sym_at(cfg_seq, j) != sym_at(cfg_seq, p_i-k+1+j)) ok_q = 1'b0;
                  end
               end
               if (ok_q) q = k;
            end
         end
      end
   end

   // Next-state selection: clear wins, then accepted symbols, else hold.
   always_comb begin
      p_d     = p_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      if (clr) begin
         p_d   = '0;
         cnt_d = '0;
      end else if (sym_if.in_valid) begin
         if (q == SEQ_LEN) begin
            match_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            p_d = cfg_overlap ? PW'(border) : '0;
         end else begin
            p_d = PW'(q);
         end
      end
   end

   // State and output registers; reset clears everything without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         p_q     <= p_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sym_if.match    = match_q;
   assign sym_if.progress = p_q;
   assign sym_if.hit_cnt  = cnt_q;
endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: directed scenarios then random traffic, checked
// against a history-based reference model. A second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_seq_detector;
   localparam int L = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [5:0] cfg_seq = 6'h39;
   logic       cfg_overlap = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_sym = 2'd0;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_detector_if #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(8)) bus8 ();
   seq_detector_if #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(2)) bus2 ();

   assign bus8.in_valid = in_valid;
   assign bus8.in_sym   = in_sym;
   assign bus2.in_valid = in_valid;
   assign bus2.in_sym   = in_sym;

   seq_detector #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_seq(cfg_seq),
      .cfg_overlap(cfg_overlap), .sym_if(bus8));

   seq_detector #(.SYM_W(2), .SEQ_LEN(3), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_seq(cfg_seq),
      .cfg_overlap(cfg_overlap), .sym_if(bus2));

   // clock
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int  m_hist[$];
   int  m_pat[L];
   bit  m_ov;
   bit  m_match;
   int  m_cnt8;
   int  m_cnt2;
   logic [12:0] exp_q[$];   // {match, progress[1:0], cnt8[7:0], cnt2[1:0]}

   function automatic int m_progress();
      int n;
      bit ok;
      n = m_hist.size();
      for (int k = L-1; k >= 1; k--) begin
         if (n >= k) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
               if (m_hist[n-k+j] != m_pat[j]) ok = 1'b0;
            if (ok) return k;
         end
      end
      return 0;
   endfunction

   function automatic bit m_full_match();
      int n;
      n = m_hist.size();
      if (n < L) return 1'b0;
      for (int j = 0; j < L; j++)
         if (m_hist[n-L+j] != m_pat[j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_push_exp();
      logic [1:0] pg;
      logic [7:0] c8;
      logic [1:0] c2;
      pg = 2'(m_progress());
      c8 = 8'(m_cnt8);
      c2 = 2'(m_cnt2);
      exp_q.push_back({m_match, pg, c8, c2});
   endtask

   task automatic m_reset();
      m_hist.delete();
      m_match = 1'b0;
      m_cnt8  = 0;
      m_cnt2  = 0;
   endtask

   task automatic m_edge(input bit v, input int sym, input bit c);
      if (c) begin
         m_reset();
         for (int i = 0; i < L; i++) m_pat[i] = int'(cfg_seq[i*2 +: 2]);
         m_ov = cfg_overlap;
      end else if (v) begin
         m_hist.push_back(sym);
         while (m_hist.size() > L) void'(m_hist.pop_front());
         m_match = m_full_match();
         if (m_match) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
            if (!m_ov) m_hist.delete();
         end
      end else begin
         m_match = 1'b0;
      end
      m_push_exp();
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [12:0] e;
      if (exp_q.size() == 0) begin
         check({tag, " exp_q_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check({tag, " match"},     32'(bus8.match),    32'(e[12]));
      check({tag, " progress"},  32'(bus8.progress), 32'(e[11:10]));
      check({tag, " hit_cnt"},   32'(bus8.hit_cnt),  32'(e[9:2]));
      check({tag, " sat_match"}, 32'(bus2.match),    32'(e[12]));
      check({tag, " sat_cnt"},   32'(bus2.hit_cnt),  32'(e[1:0]));
   endtask

   // ---------------- drivers ----------------
   task automatic step(input string tag, input bit v, input int sym, input bit c);
      @(negedge clk);
      in_valid = v;
      in_sym   = 2'(sym);
      clr      = c;
      @(posedge clk);
      m_edge(v, sym, c);
      #1;
      check_all(tag);
   endtask

   task automatic load_cfg(input string tag, input logic [5:0] seq, input bit ov);
      @(negedge clk);
      cfg_seq     = seq;
      cfg_overlap = ov;
      step(tag, 1'b0, 0, 1'b1);
   endtask

   task automatic feed(input string tag, input int syms[$]);
      foreach (syms[i]) step(tag, 1'b1, syms[i], 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      m_reset();
      for (int i = 0; i < L; i++) m_pat[i] = int'(cfg_seq[i*2 +: 2]);
      m_ov = cfg_overlap;

      // reset state without any clock edge
      #1;
      m_push_exp();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1. basic 1,2,3
      load_cfg("cfg123", 6'h39, 1'b0);
      feed("basic", '{1, 2, 3});
      step("basic_idle", 1'b0, 0, 1'b0);

      // 2. fallback
      load_cfg("clr_fb1", 6'h39, 1'b0);
      feed("fb_1123", '{1, 1, 2, 3});
      load_cfg("clr_fb2", 6'h39, 1'b0);
      feed("fb_12123", '{1, 2, 1, 2, 3});

      // 3. overlap on/off with pattern 1,2,1
      load_cfg("cfg121_ov", 6'h19, 1'b1);
      feed("ov_on", '{1, 2, 1, 2, 1});
      load_cfg("cfg121_no", 6'h19, 1'b0);
      feed("ov_off", '{1, 2, 1, 2, 1});

      // 4. back-to-back with pattern 3,3,3
      load_cfg("cfg333", 6'h3F, 1'b1);
      feed("b2b", '{3, 3, 3, 3, 3});

      // 5. gaps and clear
      load_cfg("cfg123_gap", 6'h39, 1'b0);
      step("gap", 1'b1, 1, 1'b0);
      step("gap", 1'b0, 2, 1'b0);
      step("gap", 1'b0, 3, 1'b0);
      feed("gap", '{2, 3});
      feed("clr_race", '{1, 2});
      step("clr_race", 1'b1, 3, 1'b1);
      step("clr_race_idle", 1'b0, 0, 1'b0);

      // 6a. asynchronous reset mid-cycle after 1,2
      feed("rst", '{1, 2});
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      m_push_exp();
      check_all("rst_async");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step("rst_after", 1'b1, 3, 1'b0);

      // 6b. saturation: pattern 3,3,3 overlapped, eight '3's -> six matches
      load_cfg("cfg_sat", 6'h3F, 1'b1);
      feed("sat", '{3, 3, 3, 3, 3, 3, 3, 3});
      step("sat_hold", 1'b0, 0, 1'b0);

      // random traffic with occasional reconfiguration under clear
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            load_cfg("rnd_cfg", 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
         end else begin
            step("rnd", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
